// File: rtl/sumador_drv_pkg.sv
// Shared types and constants for the sumador driver: FSM states, defaults and
// instruction field positions.
package sumador_drv_pkg;

    localparam int unsigned DefaultW  = 14;
    localparam int unsigned DefaultAW = 3;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StIssue,
        StDone
    } state_e;

    // Field order from LSB upwards: rc, rb, ra, rd, oper.
    localparam int unsigned FieldRc   = 0;
    localparam int unsigned FieldRb   = 1;
    localparam int unsigned FieldRa   = 2;
    localparam int unsigned FieldRd   = 3;
    localparam int unsigned FieldOper = 4;
    localparam int unsigned OperWidth = 2;

    function automatic int unsigned instr_width(input int unsigned aw);
        return OperWidth + 4 * aw;
    endfunction

    function automatic int unsigned field_lsb(input int unsigned aw, input int unsigned field);
        return field * aw;
    endfunction

    // Field bounds for the default 14-bit instruction word.
    localparam int unsigned RcLsb   = 0;
    localparam int unsigned RcMsb   = 2;
    localparam int unsigned RbLsb   = 3;
    localparam int unsigned RbMsb   = 5;
    localparam int unsigned RaLsb   = 6;
    localparam int unsigned RaMsb   = 8;
    localparam int unsigned RdLsb   = 9;
    localparam int unsigned RdMsb   = 11;
    localparam int unsigned OperLsb = 12;
    localparam int unsigned OperMsb = 13;

endpackage

// File: rtl/sumador_drv_regfile.sv
// 2^AW x W register file: three asynchronous read ports, one write port,
// R0 hard-wired to zero, synchronous active-low clear.
module sumador_drv_regfile
    import sumador_drv_pkg::*;
#(
    parameter int unsigned W  = DefaultW,
    parameter int unsigned AW = DefaultAW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    input  logic [AW-1:0] raddr_c,
    output logic [W-1:0]  rdata_a,
    output logic [W-1:0]  rdata_b,
    output logic [W-1:0]  rdata_c
);

    localparam int unsigned Depth = 1 << AW;

    logic [W-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];
    assign rdata_c = (raddr_c == '0) ? '0 : mem[raddr_c];

endmodule

// File: rtl/sumador_driver.sv
// Sequential initiator for the combinational sumador: fetches three operands,
// drives one enable cycle, captures the result and writes it back.
module sumador_driver
    import sumador_drv_pkg::*;
#(
    parameter int unsigned W  = DefaultW,
    parameter int unsigned AW = DefaultAW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       instr_valid,
    input  logic [OperWidth+4*AW-1:0]  instr,
    output logic                       instr_ready,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_addr,
    input  logic [W-1:0]               ld_data,
    output logic                       ld_ready,
    output logic [W-1:0]               a,
    output logic [W-1:0]               b,
    output logic [W-1:0]               c,
    output logic [1:0]                 oper,
    output logic                       en,
    input  logic [W-1:0]               res,
    output logic                       done,
    output logic [W-1:0]               result,
    output logic [15:0]                op_count
);

    localparam int unsigned IW       = instr_width(AW);
    localparam int unsigned RcLsbP   = field_lsb(AW, FieldRc);
    localparam int unsigned RbLsbP   = field_lsb(AW, FieldRb);
    localparam int unsigned RaLsbP   = field_lsb(AW, FieldRa);
    localparam int unsigned RdLsbP   = field_lsb(AW, FieldRd);
    localparam int unsigned OperLsbP = field_lsb(AW, FieldOper);

    state_e        state;
    logic [IW-1:0] instr_q;

    logic [AW-1:0] rd_addr;
    logic [AW-1:0] ra_addr;
    logic [AW-1:0] rb_addr;
    logic [AW-1:0] rc_addr;
    logic [1:0]    instr_oper;

    assign rd_addr    = instr_q[RdLsbP +: AW];
    assign ra_addr    = instr_q[RaLsbP +: AW];
    assign rb_addr    = instr_q[RbLsbP +: AW];
    assign rc_addr    = instr_q[RcLsbP +: AW];
    assign instr_oper = instr_q[OperLsbP +: OperWidth];

    logic          ld_accept;
    logic          writeback;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [W-1:0]  rf_wdata;
    logic [W-1:0]  rf_a;
    logic [W-1:0]  rf_b;
    logic [W-1:0]  rf_c;

    // Preload only happens in IDLE and writeback only in ISSUE, so the
    // single write port never sees both at once.
    assign ld_accept = (state == StIdle) && ld_valid;
    assign writeback = (state == StIssue);
    assign rf_we     = ld_accept || writeback;
    assign rf_waddr  = writeback ? rd_addr : ld_addr;
    assign rf_wdata  = writeback ? res : ld_data;

    sumador_drv_regfile #(
        .W  (W),
        .AW (AW)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (ra_addr),
        .raddr_b (rb_addr),
        .raddr_c (rc_addr),
        .rdata_a (rf_a),
        .rdata_b (rf_b),
        .rdata_c (rf_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= StIdle;
            instr_q  <= '0;
            a        <= '0;
            b        <= '0;
            c        <= '0;
            oper     <= '0;
            en       <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            op_count <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        state   <= StRead;
                    end
                end
                StRead: begin
                    a     <= rf_a;
                    b     <= rf_b;
                    c     <= rf_c;
                    oper  <= instr_oper;
                    en    <= 1'b1;
                    state <= StIssue;
                end
                StIssue: begin
                    // Full ISSUE cycle gives the combinational unit time to settle.
                    result <= res;
                    en     <= 1'b0;
                    done   <= 1'b1;
                    state  <= StDone;
                end
                StDone: begin
                    done     <= 1'b0;
                    op_count <= op_count + 16'd1;
                    state    <= StIdle;
                end
                default: begin
                    en    <= 1'b0;
                    done  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

    assign instr_ready = (state == StIdle);
    assign ld_ready    = (state == StIdle);

endmodule

// File: tb/tb_sumador_driver.sv
// Self-checking bench for sumador_driver: timeline model of the driver plus
// directed vectors with hand-computed results.
module tb_sumador_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [13:0] instr = '0;
    logic        instr_ready;
    logic        ld_valid = 1'b0;
    logic [2:0]  ld_addr = '0;
    logic [13:0] ld_data = '0;
    logic        ld_ready;
    logic [13:0] a, b, c;
    logic [1:0]  oper;
    logic        en;
    logic [13:0] res;
    logic        done;
    logic [13:0] result;
    logic [15:0] op_count;

    sumador_driver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .a           (a),
        .b           (b),
        .c           (c),
        .oper        (oper),
        .en          (en),
        .res         (res),
        .done        (done),
        .result      (result),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    // Stub of the combinational sumador.
    always_comb begin
        res = '0;
        if (en) res = (oper == 2'd2) ? a + b + c : a + b;
    end

    // Model: per-edge timeline relative to the acceptance edge.
    logic [13:0] mrf [8];
    logic [13:0] ma = '0, mb = '0, mc = '0, mres = '0;
    logic [1:0]  moper = '0;
    logic        men = 1'b0, mdone = 1'b0, busy = 1'b0;
    logic [15:0] mcnt = '0;
    logic [13:0] mi = '0;
    int          eidx = 0;
    int          acc = 0;

    initial begin
        logic        was_idle;
        logic [13:0] r;
        for (int i = 0; i < 8; i++) mrf[i] = '0;
        forever begin
            @(posedge clk);
            eidx++;
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) mrf[i] = '0;
                busy = 0; men = 0; mdone = 0;
                ma = '0; mb = '0; mc = '0; moper = '0; mres = '0; mcnt = '0;
            end else begin
                was_idle = !busy;
                if (busy && eidx == acc + 1) begin
                    ma = mrf[mi[8:6]]; mb = mrf[mi[5:3]]; mc = mrf[mi[2:0]];
                    moper = mi[13:12];
                    men = 1;
                end else if (busy && eidx == acc + 2) begin
                    r = (moper == 2'd2) ? ma + mb + mc : ma + mb;
                    mres = r;
                    if (mi[11:9] != 3'd0) mrf[mi[11:9]] = r;
                    men = 0;
                    mdone = 1;
                end else if (busy && eidx == acc + 3) begin
                    mdone = 0;
                    mcnt = mcnt + 16'd1;
                    busy = 0;
                end
                if (was_idle) begin
                    if (ld_valid && ld_addr != 3'd0) mrf[ld_addr] = ld_data;
                    if (instr_valid) begin
                        mi = instr;
                        acc = eidx;
                        busy = 1;
                    end
                end
            end
        end
    end

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    task automatic compare_all();
        chk("instr_ready", instr_ready, !busy);
        chk("ld_ready", ld_ready, !busy);
        chk("en", en, men);
        chk("done", done, mdone);
        chk("a", a, ma);
        chk("b", b, mb);
        chk("c", c, mc);
        chk("oper", oper, moper);
        chk("result", result, mres);
        chk("op_count", op_count, mcnt);
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
        cyc++;
        if (en) last_en = cyc;
        compare_all();
    endtask

    function automatic logic [13:0] enc(input int op, input int rd, input int ra,
                                        input int rb, input int rc);
        logic [1:0] o;
        logic [2:0] d, x, y, z;
        o = op[1:0]; d = rd[2:0]; x = ra[2:0]; y = rb[2:0]; z = rc[2:0];
        return {o, d, x, y, z};
    endfunction

    task automatic preload(input int addr, input int data);
        int n = 0;
        ld_valid = 1; ld_addr = addr[2:0]; ld_data = data[13:0];
        while (!ld_ready && n < 20) begin cycle(); n++; end
        if (!ld_ready) timeout("preload_wait");
        cycle();
        ld_valid = 0;
    endtask

    task automatic issue(input logic [13:0] w);
        int n = 0;
        instr_valid = 1; instr = w;
        while (!instr_ready && n < 20) begin cycle(); n++; end
        if (!instr_ready) timeout("issue_wait");
        cycle();
        instr_valid = 0;
    endtask

    task automatic run_op(input logic [13:0] w);
        issue(w);
        repeat (3) cycle();
    endtask

    initial begin
        int e1;
        int e2;
        // Reset and idle
        rst_n = 0;
        repeat (2) cycle();
        rst_n = 1;
        chk("rst_ready", instr_ready, 1);
        chk("rst_en", en, 0);
        chk("rst_result", result, 0);
        chk("rst_count", op_count, 0);

        // Preload and add
        preload(1, 1); preload(2, 2); preload(3, 3);
        issue(enc(2, 4, 1, 2, 3));
        chk("add_read_en", en, 0);
        cycle();
        chk("add_en", en, 1);
        chk("add_a", a, 1); chk("add_b", b, 2); chk("add_c", c, 3);
        cycle();
        chk("add_done", done, 1);
        chk("add_result", result, 6);
        cycle();
        chk("add_count", op_count, 1);
        run_op(enc(0, 7, 4, 0, 0));
        chk("r4_value", result, 6);

        // Dependency through writeback
        preload(1, 121); preload(2, 12); preload(3, 100);
        run_op(enc(2, 5, 1, 2, 3));
        chk("dep_first", result, 233);
        e1 = last_en;
        run_op(enc(0, 6, 5, 5, 0));
        e2 = last_en;
        chk("dep_result", result, 466);
        chk("en_spacing", e2 - e1, 4);

        // Boundaries: wrap and R0
        preload(1, 14'h3FFF); preload(2, 1);
        run_op(enc(0, 0, 1, 2, 0));
        chk("wrap_result", result, 0);
        run_op(enc(0, 0, 1, 1, 0));
        chk("r0_capture", result, 14'h3FFE);
        issue(enc(0, 7, 0, 2, 0));
        cycle();
        chk("r0_a", a, 0);
        repeat (2) cycle();
        chk("r0_result", result, 1);

        // Reset during ISSUE
        preload(1, 5); preload(2, 6);
        issue(enc(0, 3, 1, 2, 0));
        cycle();
        chk("mid_en", en, 1);
        rst_n = 0;
        cycle();
        rst_n = 1;
        chk("mid_done", done, 0);
        chk("mid_idle", instr_ready, 1);
        chk("mid_count", op_count, 0);
        repeat (3) cycle();
        preload(1, 9);
        run_op(enc(0, 7, 3, 1, 0));
        chk("mid_rd_cleared", result, 9);

        // Preload gating while busy
        issue(enc(0, 6, 2, 0, 0));
        ld_valid = 1; ld_addr = 3'd2; ld_data = 14'd40;
        chk("gate_read", ld_ready, 0);
        cycle();
        chk("gate_issue", ld_ready, 0);
        chk("gate_a", a, 0);
        cycle();
        chk("gate_done", ld_ready, 0);
        cycle();
        chk("gate_idle", ld_ready, 1);
        cycle();
        ld_valid = 0;

        // Preload and instruction in the same IDLE cycle
        ld_valid = 1; ld_addr = 3'd4; ld_data = 14'd77;
        instr_valid = 1; instr = enc(0, 7, 4, 2, 0);
        cycle();
        ld_valid = 0; instr_valid = 0;
        cycle();
        chk("same_a", a, 77);
        chk("same_b", b, 40);
        cycle();
        chk("same_result", result, 117);
        repeat (2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
